// File: rtl/lu_ifetch.sv
// lu_ifetch: instruction prefetch unit.
//
// Fetches instruction words from a synchronous single-cycle-latency memory
// into a small prefetch FIFO and presents the FIFO head to the processor
// as icode / icode_pc with a valid/ready handshake.
//
// States: IDLE (after reset), RUN (fetching), HALT (fetch stopped by a
// halt word; FIFO still drains). A redirect in RUN flushes the FIFO, kills
// the outstanding read and restarts fetch from redirect_addr.
//
// Optional feature: define LU_IFETCH_HALT_EN to make an all-ones word stop
// fetching (enter HALT). Without it, all-ones is an ordinary instruction,
// HALT is unreachable and halted is tied low.

module lu_ifetch #(
    parameter int ADDR_W = 4,
    parameter int IW     = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [IW-1:0]     mem_rd_data,
    output logic [IW-1:0]     icode,
    output logic              icode_valid,
    input  logic              icode_ready,
    output logic [ADDR_W-1:0] icode_pc,
    output logic              busy,
    output logic              halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
`ifdef LU_IFETCH_HALT_EN
    localparam logic [IW-1:0] HALT_WORD = '1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    // Control state
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              inflight;       // a read was issued on the previous edge
    logic [ADDR_W-1:0] inflight_addr;  // address of that read
    logic              busy_q;
`ifdef LU_IFETCH_HALT_EN
    logic              halted_q;
`endif

    // Prefetch FIFO
    logic [IW-1:0]     fifo_code [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Per-cycle decisions
    logic              empty;
    logic              redirect_take;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              halt_hit;

    // Decide this cycle's issue, push, pop and halt events
    always_comb begin
        // NOTE: every variable gets a value on every path through this block,
        // so no latch is inferred; blocking '=' is correct in combinational
        // logic, non-blocking '<=' is reserved for clocked state.
        empty         = (count == '0);
        redirect_take = redirect && (state == ST_RUN);
        // Credit counts the registered FIFO level plus the outstanding read;
        // a pop in this same cycle deliberately earns no credit yet.
        occupancy     = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue         = (state == ST_RUN) && !redirect_take
                        && (occupancy < {1'b0, DEPTH_CNT});
        // Returning data of a read overtaken by a redirect is dropped.
        push          = inflight && !redirect_take;
        pop           = !empty && icode_ready && !redirect_take;
`ifdef LU_IFETCH_HALT_EN
        halt_hit      = push && (mem_rd_data == HALT_WORD);
`else
        halt_hit      = 1'b0;
`endif
    end

    // Control FSM: run state, fetch pc, outstanding read and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            busy_q        <= 1'b0;
`ifdef LU_IFETCH_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc;
                pc            <= pc + ADDR_W'(1);
            end
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state  <= ST_RUN;
                        pc     <= start_addr;
                        busy_q <= 1'b1;
`ifdef LU_IFETCH_HALT_EN
                        halted_q <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        // issue is already suppressed, so inflight clears
                        pc <= redirect_addr;
                    end else if (halt_hit) begin
                        // The read issued alongside the halt word is killed.
                        state    <= ST_HALT;
                        inflight <= 1'b0;
`ifdef LU_IFETCH_HALT_EN
                        halted_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and level; a redirect flushes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_take) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write; credit accounting guarantees it is never full here
    // NOTE: the storage array has no reset; validity is tracked solely by the
    // reset pointers/level, and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_code[wr_ptr] <= mem_rd_data;
            fifo_pc[wr_ptr]   <= inflight_addr;
        end
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = pc;

    assign icode_valid = !empty;
    assign icode       = empty ? '0 : fifo_code[rd_ptr];
    assign icode_pc    = empty ? '0 : fifo_pc[rd_ptr];

    assign busy        = busy_q;
`ifdef LU_IFETCH_HALT_EN
    assign halted      = halted_q;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_lu_ifetch.sv
// tb_lu_ifetch: self-checking bench for lu_ifetch with a synchronous
// instruction memory model (mem[a] = 8'h10 + a unless overridden).

module tb_lu_ifetch;

    localparam int ADDR_W = 4;
    localparam int IW     = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [IW-1:0]     mem_rd_data = '0;
    logic [IW-1:0]     icode;
    logic              icode_valid;
    logic              icode_ready = 1'b0;
    logic [ADDR_W-1:0] icode_pc;
    logic              busy;
    logic              halted;

    always #5 clk = ~clk;

    lu_ifetch #(.ADDR_W(ADDR_W), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .icode        (icode),
        .icode_valid  (icode_valid),
        .icode_ready  (icode_ready),
        .icode_pc     (icode_pc),
        .busy         (busy),
        .halted       (halted)
    );

    // Memory model with read logging
    logic [IW-1:0] mem [16];
    int rd_count = 0;
    int rd_hits [16];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data           <= mem[mem_rd_addr];
            rd_count              <= rd_count + 1;
            rd_hits[mem_rd_addr]  <= rd_hits[mem_rd_addr] + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        start       = 1'b0;
        redirect    = 1'b0;
        icode_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Expect n consecutive deliveries from first_addr (icode_ready held by caller)
    task automatic expect_deliveries(input string tag, input int n, input int first_addr,
                                     input int max_cycles);
        int got;
        int a;
        got = 0;
        for (int c = 0; c < max_cycles && got < n; c++) begin
            @(negedge clk);
            #1;
            if (icode_valid) begin
                a = (first_addr + got) % 16;
                check($sformatf("%s icode[%0d]", tag, got), icode, mem[a]);
                check($sformatf("%s pc[%0d]", tag, got), icode_pc, a);
                got++;
            end
        end
        check($sformatf("%s delivered count", tag), got, n);
    endtask

    typedef struct {
        logic              start;
        logic              ready;
        logic              exp_rd_en;
        logic [ADDR_W-1:0] exp_rd_addr;
        logic              exp_valid;
        logic [IW-1:0]     exp_icode;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_busy;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int rd_base;
        int hit7_base;
        logic found;

        for (int a = 0; a < 16; a++) mem[a] = IW'(8'h10 + a);

        // Streaming table: start in cycle 0, ready held high
        vecs[0] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'h00, 4'h0, 1'b1};
        for (int k = 3; k < 20; k++) begin
            vecs[k] = '{1'b0, 1'b1, 1'b1, ADDR_W'((k - 1) % 16), 1'b1,
                        IW'(8'h10 + ((k - 3) % 16)), ADDR_W'((k - 3) % 16), 1'b1};
        end

        // Asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        check("reset icode_valid", icode_valid, 0);
        check("reset icode", icode, 0);
        check("reset icode_pc", icode_pc, 0);
        check("reset mem_rd_en", mem_rd_en, 0);
        check("reset busy", busy, 0);
        check("reset halted", halted, 0);

        // Full-speed stream with address wrap
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start       = vecs[i].start;
            start_addr  = '0;
            icode_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d rd_en", i), mem_rd_en, vecs[i].exp_rd_en);
            if (vecs[i].exp_rd_en)
                check($sformatf("vec%0d rd_addr", i), mem_rd_addr, vecs[i].exp_rd_addr);
            check($sformatf("vec%0d valid", i), icode_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d icode", i), icode, vecs[i].exp_icode);
                check($sformatf("vec%0d pc", i), icode_pc, vecs[i].exp_pc);
            end
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
        end

        // Back-pressure: ready low for 10 cycles, start in RUN ignored
        do_reset();
        @(negedge clk);
        start = 1'b1; start_addr = '0; icode_ready = 1'b0;
        rd_base = rd_count;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = (c == 6);
            start_addr = (c == 6) ? 4'h9 : 4'h0;
            #1;
            if (c >= 3) begin
                check($sformatf("bp c%0d valid", c), icode_valid, 1);
                check($sformatf("bp c%0d icode held", c), icode, 8'h10);
                check($sformatf("bp c%0d pc held", c), icode_pc, 0);
            end
        end
        check("bp reads issued", rd_count - rd_base, DEPTH);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            icode_ready = 1'b1;
            #1;
            check($sformatf("bp drain%0d valid", i), icode_valid, 1);
            check($sformatf("bp drain%0d icode", i), icode, 8'h10 + i);
            check($sformatf("bp drain%0d pc", i), icode_pc, i);
        end

        // Redirect to 4'hA while icode_pc = 3
        do_reset();
        @(negedge clk);
        start = 1'b1; start_addr = '0; icode_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (icode_valid && icode_pc == 4'h3) found = 1'b1;
            else @(negedge clk);
        end
        check("redir found pc3", found, 1);
        redirect = 1'b1; redirect_addr = 4'hA;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("redir valid dropped", icode_valid, 0);
        expect_deliveries("redir", 3, 10, 20);

`ifdef LU_IFETCH_HALT_EN
        // Halt word at address 5
        do_reset();
        mem[5] = 8'hFF;
        hit7_base = rd_hits[7];
        @(negedge clk);
        start = 1'b1; start_addr = '0; icode_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_deliveries("halt", 6, 0, 20);
        repeat (3) @(negedge clk);
        #1;
        check("halt halted", halted, 1);
        check("halt busy", busy, 1);
        check("halt drained", icode_valid, 0);
        check("halt no read addr7", rd_hits[7] - hit7_base, 0);
        @(negedge clk);
        start = 1'b1; start_addr = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("restart halted cleared", halted, 0);
        expect_deliveries("restart", 1, 0, 6);
        mem[5] = 8'h15;
`else
        // All-ones is an ordinary instruction
        do_reset();
        mem[5] = 8'hFF;
        @(negedge clk);
        start = 1'b1; start_addr = '0; icode_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_deliveries("ff passes", 9, 0, 20);
        check("ff halted low", halted, 0);
        check("ff still fetching", mem_rd_en, 1);
        mem[5] = 8'h15;
`endif

        // Reset mid-stream with three entries queued
        do_reset();
        @(negedge clk);
        start = 1'b1; start_addr = '0; icode_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("midrst queued valid", icode_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst async valid", icode_valid, 0);
        check("midrst async busy", busy, 0);
        check("midrst async icode", icode, 0);
        check("midrst async rd_en", mem_rd_en, 0);
        @(negedge clk);
        rst = 1'b1; icode_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            redirect = (c == 0);
            redirect_addr = 4'h7;
            #1;
            check($sformatf("post-rst c%0d valid", c), icode_valid, 0);
            check($sformatf("post-rst c%0d busy", c), busy, 0);
            check($sformatf("post-rst c%0d rd_en", c), mem_rd_en, 0);
        end
        @(negedge clk);
        redirect = 1'b0;
        start = 1'b1; start_addr = '0;
        @(negedge clk);
        start = 1'b0;
        expect_deliveries("post-rst start", 2, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
